seven_seg_one_dig: RTL and testbench

SEVEN_SEG_ONE_DIG -- requirements
Module: seven_seg_one_dig

---
 rtl/seven_seg_one_dig_if.sv | 29 ++
 rtl/seven_seg_one_dig.sv | 78 +++++++
 tb/tb_seven_seg_one_dig.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seven_seg_one_dig_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_one_dig_if
// Description : Data bundle between a hex-digit source and the single-digit
//               seven-segment decoder. The source drives the 4-bit digit and
//               the decoder returns the registered 8-bit segment drive.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_one_dig_if;

   // Hex digit to display, 0x0..0xF
   logic [3:0] in;
   // Segment drive {dp, g, f, e, d, c, b, a}
   logic [7:0] sevenSeg;

   // Digit source side
   modport master (
      output in,
      input  sevenSeg
   );

   // Decoder side
   modport slave (
      input  in,
      output sevenSeg
   );

endinterface : seven_seg_one_dig_if
`default_nettype wire

// File: rtl/seven_seg_one_dig.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_one_dig
// Description : Single-digit hexadecimal seven-segment decoder with a
//               registered output and one cycle of latency. Segment polarity
//               is selectable: ACTIVE_LOW=1 drives a common-anode display
//               (0 lights a segment), ACTIVE_LOW=0 a common-cathode display.
//               The decimal point is always off. The reset is asynchronous
//               and active-low and blanks the display without needing a clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_one_dig #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  wire logic             clk,
   input  wire logic             rst,   // asynchronous, active-low
   seven_seg_one_dig_if.slave    bus
);

   // Pattern with every segment and the decimal point dark, in output polarity.
   localparam logic [7:0] c_blank = ACTIVE_LOW ? 8'hFF : 8'h00;

   // Decoded glyph in positive logic (1 = segment lit), bits {g,f,e,d,c,b,a}.
   logic [6:0] w_glyph;
   // Glyph plus a dark decimal point, converted to the display's polarity.
   logic [7:0] w_drive;
   // The only state in the block: the segment drive register.
   logic [7:0] r_seg;

   // Hex-to-glyph lookup; all sixteen codes are listed so every input has a
   // defined pattern. The initial blank assignment only matters for
   // non-binary input values and keeps the block free of latches.
   always_comb begin
      w_glyph = 7'h00;
      case (bus.in)
         4'h0: w_glyph = 7'h3F;
         4'h1: w_glyph = 7'h06;
         4'h2: w_glyph = 7'h5B;
         4'h3: w_glyph = 7'h4F;
         4'h4: w_glyph = 7'h66;
         4'h5: w_glyph = 7'h6D;
         4'h6: w_glyph = 7'h7D;
         4'h7: w_glyph = 7'h07;
         4'h8: w_glyph = 7'h7F;
         4'h9: w_glyph = 7'h6F;
         4'hA: w_glyph = 7'h77;
         4'hB: w_glyph = 7'h7C;   // lowercase b
         4'hC: w_glyph = 7'h39;
         4'hD: w_glyph = 7'h5E;   // lowercase d
         4'hE: w_glyph = 7'h79;
         4'hF: w_glyph = 7'h71;
      endcase
   end

   // Polarity is fixed at build time, so it is resolved structurally rather
   // than with a run-time mux. The decimal point is carried as an unlit bit.
   generate
      if (ACTIVE_LOW) begin : g_active_low
         assign w_drive = ~{1'b0, w_glyph};
      end else begin : g_active_high
         assign w_drive = {1'b0, w_glyph};
      end
   endgenerate

   // Segment register: blank immediately while reset is low, otherwise load
   // the decode of the current digit on every rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_seg <= c_blank;
      end else begin
         r_seg <= w_drive;
      end
   end

   assign bus.sevenSeg = r_seg;

endmodule : seven_seg_one_dig
`default_nettype wire

// File: tb/tb_seven_seg_one_dig.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_one_dig
// Description : Directed self-checking bench for seven_seg_one_dig. Two
//               instances share clock and reset: one common-anode build and
//               one common-cathode build, each checked against its own
//               hand-written glyph table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_one_dig;

   logic clk;
   logic rst;

   int n_checks;
   int n_fails;

   // Expected common-anode codes, digit 0..F
   logic [7:0] c_exp_al [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };
   // Expected common-cathode codes, digit 0..F
   logic [7:0] c_exp_ah [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   seven_seg_one_dig_if bus_al ();
   seven_seg_one_dig_if bus_ah ();

   seven_seg_one_dig #(.ACTIVE_LOW(1'b1)) u_dut_al (
      .clk (clk),
      .rst (rst),
      .bus (bus_al)
   );

   seven_seg_one_dig #(.ACTIVE_LOW(1'b0)) u_dut_ah (
      .clk (clk),
      .rst (rst),
      .bus (bus_ah)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst       = 1'b0;
      bus_al.in = 4'h8;
      bus_ah.in = 4'h8;

      // Reset held with the clock running: both displays stay blank
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_al", bus_al.sevenSeg, 8'hFF);
         check("rst_hold_ah", bus_ah.sevenSeg, 8'h00);
      end

      // Release between edges: still blank until the first rising edge
      rst = 1'b1;
      #1;
      check("rst_rel_blank_al", bus_al.sevenSeg, 8'hFF);
      check("rst_rel_blank_ah", bus_ah.sevenSeg, 8'h00);
      @(negedge clk);
      check("rst_first_load_al", bus_al.sevenSeg, 8'h80);
      check("rst_first_load_ah", bus_ah.sevenSeg, 8'h7F);

      // Full sweep, new digit every cycle, checked one cycle later
      for (int v = 0; v < 16; v++) begin
         bus_al.in = v[3:0];
         bus_ah.in = v[3:0];
         @(negedge clk);
         check($sformatf("sweep_al_%0h", v), bus_al.sevenSeg, c_exp_al[v]);
         check($sformatf("sweep_ah_%0h", v), bus_ah.sevenSeg, c_exp_ah[v]);
         check($sformatf("dp_al_%0h", v), {7'b0, bus_al.sevenSeg[7]}, 8'h01);
         check($sformatf("dp_ah_%0h", v), {7'b0, bus_ah.sevenSeg[7]}, 8'h00);
      end

      // Input change between edges must not reach the output early
      bus_al.in = 4'h2;
      bus_ah.in = 4'h2;
      @(negedge clk);
      check("hold_pre_al", bus_al.sevenSeg, 8'hA4);
      #2;
      bus_al.in = 4'h3;
      bus_ah.in = 4'h3;
      #1;
      check("hold_mid_al", bus_al.sevenSeg, 8'hA4);
      check("hold_mid_ah", bus_ah.sevenSeg, 8'h5B);
      @(posedge clk);
      #1;
      check("hold_post_al", bus_al.sevenSeg, 8'hB0);
      check("hold_post_ah", bus_ah.sevenSeg, 8'h4F);

      // Asynchronous reset between edges blanks before the next edge
      @(negedge clk);
      bus_al.in = 4'h1;
      bus_ah.in = 4'h1;
      @(negedge clk);
      check("arst_pre_al", bus_al.sevenSeg, 8'hF9);
      #2;
      rst = 1'b0;
      #1;
      check("arst_blank_al", bus_al.sevenSeg, 8'hFF);
      check("arst_blank_ah", bus_ah.sevenSeg, 8'h00);
      @(negedge clk);
      check("arst_held_al", bus_al.sevenSeg, 8'hFF);
      rst = 1'b1;
      @(negedge clk);
      check("arst_reload_al", bus_al.sevenSeg, 8'hF9);
      check("arst_reload_ah", bus_ah.sevenSeg, 8'h06);

      // Common-cathode build: 0 then F, one cycle after each input
      bus_ah.in = 4'h0;
      @(negedge clk);
      check("pol_ah_0", bus_ah.sevenSeg, 8'h3F);
      bus_ah.in = 4'hF;
      @(negedge clk);
      check("pol_ah_f", bus_ah.sevenSeg, 8'h71);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule : tb_seven_seg_one_dig
`default_nettype wire
